// File: rtl/seqdetect_pkg.sv
// Shared constants for the 11010 sequence detector and its match event logger.
package seqdetect_pkg;

  localparam int IDX_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 8;

  localparam int                 PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b11010;

  // Occupancy states, decoded from the FIFO level
  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  function automatic logic [1:0] occ_state(input int unsigned lvl, input int unsigned depth);
    logic [1:0] st;
    if (lvl == 32'd0) begin
      st = OCC_EMPTY;
    end else if (lvl >= depth) begin
      st = OCC_FULL;
    end else begin
      st = OCC_PARTIAL;
    end
    return st;
  endfunction

endpackage

// File: rtl/match_event_logger_fifo.sv
// Single-clock FIFO with level tracking and a registered head entry (1-cycle latency).
module match_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             rd_valid_r;
  logic [W-1:0]     rd_data_r;

  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [LVL_W-1:0] level_next_s;
  logic [LVL_W-1:0] level_after_pop_s;
  logic [W-1:0]     head_next_s;

  // Next level, read pointer and the entry that becomes the head after this edge
  always_comb begin
    rd_ptr_next_s     = rd_ptr_r;
    level_next_s      = level_r;
    level_after_pop_s = level_r;
    head_next_s       = {W{1'b0}};
    if (pop) begin
      rd_ptr_next_s     = rd_ptr_r + PTR_W'(1);
      level_after_pop_s = level_r - LVL_W'(1);
    end else begin
      rd_ptr_next_s     = rd_ptr_r;
      level_after_pop_s = level_r;
    end
    case ({push, pop})
      2'b10:   level_next_s = level_r + LVL_W'(1);
      2'b01:   level_next_s = level_r - LVL_W'(1);
      default: level_next_s = level_r;
    endcase
    // An entry written this edge into an otherwise empty FIFO is the new head
    if (level_next_s == {LVL_W{1'b0}}) begin
      head_next_s = {W{1'b0}};
    end else if (push && (level_after_pop_s == {LVL_W{1'b0}})) begin
      head_next_s = wr_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, level and registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= {W{1'b0}};
    end else if (clear) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= {W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r   <= rd_ptr_next_s;
      level_r    <= level_next_s;
      rd_valid_r <= (level_next_s != {LVL_W{1'b0}});
      rd_data_r  <= head_next_s;
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign level    = level_r;

endmodule

// File: rtl/match_event_logger.sv
// Counts detector matches and queues each match's bit-index timestamp for a valid/ready reader.
module match_event_logger
  import seqdetect_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     match_in,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [IDX_W-1:0]         rd_index,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [IDX_W-1:0] bit_idx_r;
  logic [CNT_W-1:0] match_count_r;
  logic             overflow_r;

  logic             pop_s, push_s, drop_s, full_s;

  // Push/pop/drop decision; clear suppresses any same-cycle match
  always_comb begin
    full_s = (level == FULL_LVL);
    pop_s  = rd_valid && rd_ready && !clear;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (match_in && !clear) begin
      push_s = !full_s || pop_s;
      drop_s = full_s && !pop_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Bit index, saturating match counter and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx_r     <= {IDX_W{1'b0}};
      match_count_r <= {CNT_W{1'b0}};
      overflow_r    <= 1'b0;
    end else if (clear) begin
      bit_idx_r     <= {IDX_W{1'b0}};
      match_count_r <= {CNT_W{1'b0}};
      overflow_r    <= 1'b0;
    end else begin
      bit_idx_r <= bit_idx_r + IDX_W'(1);
      if (match_in && (match_count_r != {CNT_W{1'b1}})) begin
        match_count_r <= match_count_r + CNT_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  match_fifo #(
    .W     (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (push_s),
    .pop      (pop_s),
    .wr_data  (bit_idx_r),
    .rd_valid (rd_valid),
    .rd_data  (rd_index),
    .level    (level)
  );

  assign match_count = match_count_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench: a reference detector drives match_in, a scoreboard queue checks drained timestamps.
module tb_match_event_logger;
  import seqdetect_pkg::*;

  localparam int IDX_W = 16;
  localparam int CNT_W = 16;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset, match_in, clear, rd_ready;
  logic              rd_valid, overflow;
  logic [IDX_W-1:0]  rd_index;
  logic [CNT_W-1:0]  match_count;
  logic [3:0]        level;

  int vectors     = 0;
  int miscompares = 0;
  int sb_q[$];
  int mlevel      = 0;
  int midx        = 0;
  int last_pop    = -1;
  logic [PAT_LEN-1:0] shreg = '0;

  match_event_logger #(.IDX_W(IDX_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .match_in(match_in), .clear(clear), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_index(rd_index), .match_count(match_count),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pop the DUT performs is compared against the scoreboard head
  always @(negedge clk) begin
    if (reset === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got index %0d, expected no entry", rd_index);
      end else begin
        check("pop_order", 32'(rd_index), 32'(sb_q.pop_front()));
        last_pop = int'(rd_index);
      end
    end
  end

  task automatic model_reset();
    sb_q.delete();
    mlevel = 0;
    midx   = 0;
    shreg  = '0;
  endtask

  // One clock: drive inputs, push the expected timestamp if the match will be accepted
  task automatic cyc(input logic m, input logic rdy, input logic clr);
    int acc, popm;
    match_in = m;
    rd_ready = rdy;
    clear    = clr;
    popm = (mlevel > 0 && rdy && !clr) ? 1 : 0;
    acc  = (m && !clr && (mlevel < DEPTH || popm == 1)) ? 1 : 0;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      if (acc == 1) sb_q.push_back(midx);
      mlevel = mlevel + acc - popm;
      midx   = (midx + 1) % 65536;
    end
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) begin
      shreg = {shreg[PAT_LEN-2:0], bits[i]};
      cyc(shreg == PATTERN, rdy, 1'b0);
    end
  endtask

  task automatic idle_to(input int target, input logic rdy);
    while (midx != target) cyc(1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0; match_in = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_index"}, 32'(rd_index), 32'd0);
    check({tag, "_count"}, 32'(match_count), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    reset = 1'b0; match_in = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    #3 check_all_zero("reset");
    do_reset();

    // Single 11010 from index 0, then a second one ending at index 9
    send_bits(16'b11010, 5, 1'b0);
    check("t1_rd_valid", 32'(rd_valid), 32'd1);
    check("t1_rd_index", 32'(rd_index), 32'd4);
    check("t1_count", 32'(match_count), 32'd1);
    check("t1_level", 32'(level), 32'd1);
    send_bits(16'b11010, 5, 1'b0);
    check("t2_level", 32'(level), 32'd2);
    check("t2_count", 32'(match_count), 32'd2);
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    check("t2_rd_valid", 32'(rd_valid), 32'd0);
    check("t2_last", 32'(last_pop), 32'd9);

    // Nine back-to-back matches from index 20 overflow an 8-deep FIFO
    do_reset();
    idle_to(20, 1'b0);
    repeat (9) cyc(1'b1, 1'b0, 1'b0);
    check("t3_level", 32'(level), 32'd8);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count", 32'(match_count), 32'd9);
    repeat (8) cyc(1'b0, 1'b1, 1'b0);
    check("t3_last", 32'(last_pop), 32'd27);
    check("t3_empty", 32'(rd_valid), 32'd0);
    check("t3_sticky", 32'(overflow), 32'd1);

    // Full FIFO with pop and push in the same cycle at index 50
    do_reset();
    idle_to(42, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    check("t4_full", 32'(level), 32'd8);
    cyc(1'b1, 1'b1, 1'b0);
    check("t4_level", 32'(level), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd0);
    repeat (8) cyc(1'b0, 1'b1, 1'b0);
    check("t4_last", 32'(last_pop), 32'd50);
    check("t4_drained", 32'(level), 32'd0);

    // Clear wins over a coincident match at level 3
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    check("t5_pre_level", 32'(level), 32'd3);
    cyc(1'b1, 1'b0, 1'b1);
    check("t5_count", 32'(match_count), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_rd_valid", 32'(rd_valid), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t5_rd_valid2", 32'(rd_valid), 32'd1);
    check("t5_rd_index", 32'(rd_index), 32'd2);
    check("t5_count2", 32'(match_count), 32'd1);

    // Asynchronous reset in mid-cycle with level 4 and count 7
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    check("t6_level", 32'(level), 32'd4);
    check("t6_count", 32'(match_count), 32'd7);
    #2 reset = 1'b0;
    #1 check_all_zero("t6_async");
    model_reset();
    match_in = 1'b0; rd_ready = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send_bits(16'b11010, 5, 1'b0);
    check("t6_restart_valid", 32'(rd_valid), 32'd1);
    check("t6_restart_index", 32'(rd_index), 32'd4);
    cyc(1'b0, 1'b1, 1'b0);
    check("t6_final_empty", 32'(rd_valid), 32'd0);
    check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
Downstream consumer of the 11010 sequence detector's match pulse. The block counts matches and timestamps each match with the bit index at which it completed. Timestamps go into a small FIFO that a host or testbench drains over a valid/ready interface. This replaces ad-hoc simulation printing with synthesizable, observable match reporting.

Parameters:
IDX_W, 16, width of the bit-index timestamp counter
CNT_W, 16, width of the saturating total-match counter
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0); one clock domain only
match_in  in  1  one-cycle match pulse from the detector's output; may be high on consecutive cycles
clear  in  1  synchronous soft clear, active-high
rd_ready  in  1  consumer accepts the head entry
rd_valid  out  1  FIFO non-empty; rd_index is valid
rd_index  out  IDX_W  bit index of the oldest unread match
match_count  out  CNT_W  total matches since reset or clear, saturating
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; a match was dropped because the FIFO was full

Behaviour:
- Reset (reset=0) takes effect immediately, without waiting for a clock edge:
  - all outputs go to 0;
  - the internal bit_idx counter clears;
  - the FIFO pointers clear.
- bit_idx:
  - starts at 0 on the first rising edge after reset deasserts and increments by 1 on every clk edge;
  - wraps from 2^IDX_W-1 to 0, and overflow is not flagged on wrap;
  - the detector consumes one bit per clock, so bit_idx equals the index of the bit currently presented.
- Timestamp: on a cycle where match_in=1, the logged value is the current bit_idx, i.e. the index of the final 0 of 11010. First bit after reset is index 0.
- match_count:
  - increments by 1 on each cycle with match_in=1;
  - holds at 2^CNT_W-1 once reached (saturates);
  - counts every match, including matches dropped by the FIFO.
- FIFO push: occurs when match_in=1 and either (level<DEPTH) or (level==DEPTH and a pop occurs in the same cycle).
- FIFO pop: occurs when rd_valid && rd_ready.
- Simultaneous push and pop: level is unchanged. When empty, a push alone makes rd_valid=1 on the next cycle; there is no same-cycle bypass, so latency is 1 cycle.
- Full and match_in=1 with no pop: the entry is dropped, level stays DEPTH, and overflow is set on the next edge. overflow stays set until reset or clear.
- Output stability: rd_index and rd_valid are registered. rd_index must hold stable while rd_valid && !rd_ready. Order is strictly FIFO.
- Pointers: width $clog2(DEPTH) and wrap naturally. Full/empty are derived from level, not from pointer compare.
- clear=1 (synchronous) returns bit_idx, match_count, level, pointers, overflow and rd_valid to 0 on the next edge. clear has priority over a same-cycle match_in: that match is neither counted nor pushed. The bit index after the clear edge is 0.
- Occupancy states, decoded from level:
  - EMPTY (0) -> PARTIAL on push;
  - PARTIAL -> FULL when the push brings level to DEPTH;
  - FULL -> PARTIAL on pop without push;
  - PARTIAL -> EMPTY when a pop brings level to 0;
  - any state -> EMPTY on clear.
- match_in high on consecutive cycles is legal: each cycle is a separate event.

Decomposition:
- Shared package seqdetect_pkg holds:
  - IDX_W, CNT_W and DEPTH defaults;
  - the detector's pattern constant 5'b11010 and pattern length 5, for use by both detector and bench.
- One sub-module: match_fifo, a synchronous single-clock FIFO with push/pop, level and registered head output.
- match_event_logger itself holds bit_idx, match_count, overflow and the push/pop/drop decision.

Test Plan:
1. Reset, then drive the detector with 11010 from index 0; match_in pulses at bit_idx 4. Required: rd_valid=1 on the next cycle, rd_index=4, match_count=1, level=1.
2. Stream 1101011010 with rd_ready=0. Required: level=2, match_count=2. Then raise rd_ready: rd_index reads 4 then 9, and rd_valid=0 after two pops.
3. Force match_in high for 9 consecutive cycles starting at bit_idx 20 with rd_ready=0. Required: level=8, overflow=1, match_count=9, and the drained indices are 20..27.
4. FIFO full, rd_ready=1 and match_in=1 in the same cycle at bit_idx 50. Required: level stays 8, overflow stays 0, and the last drained index is 50.
5. clear=1 coincident with match_in=1 and level=3. Required: next cycle match_count=0, level=0, rd_valid=0, overflow=0; the next match 3 cycles later logs index 2.
6. Pull reset low mid-cycle with level=4 and match_count=7. Required: all outputs are 0 before the next clk edge. After release, bit_idx restarts at 0.
